alu_sweep_checker: RTL and testbench

- Sequential stimulus-and-compare stage that wraps the 4-bit ALU pair: a golden ALU and a suspect ALU.
- Drives every {op, A, B} vector (1024 total) into both ALUs and compares the two 4-bit results.
- Counts mismatches and reports pass/fail, flagging a suspect ALU that carries a hidden trojan.
- Sits directly around the ALUs: supplies their operands and consumes their results.

---
 rtl/alu_sweep_pkg.sv | 19 +
 rtl/alu_sweep_capture.sv | 44 ++++
 rtl/alu_sweep_checker.sv | 135 +++++++++++++
 tb/tb_alu_sweep_checker.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sweep_pkg.sv
// Shared types and constants for the ALU sweep checker.
package alu_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int              VEC_W    = 10;
    localparam logic [VEC_W-1:0] LAST_VEC = 10'h3FF;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

endpackage

// File: rtl/alu_sweep_capture.sv
// First-mismatch capture registers: latch {op,A,B} and both results on the
// first hit after a clear; later hits are ignored.
import alu_sweep_pkg::*;

module alu_sweep_capture (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             hit_i,
    input  logic [VEC_W-1:0] vec_i,
    input  logic [3:0]       gold_i,
    input  logic [3:0]       dut_i,
    output logic             first_valid_o,
    output logic [VEC_W-1:0] first_vec_o,
    output logic [3:0]       first_gold_o,
    output logic [3:0]       first_dut_o
);

    // Capture on the first hit, clear on a new sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_valid_o <= 1'b0;
            first_vec_o   <= '0;
            first_gold_o  <= 4'h0;
            first_dut_o   <= 4'h0;
        end else if (clr_i) begin
            first_valid_o <= 1'b0;
            first_vec_o   <= '0;
            first_gold_o  <= 4'h0;
            first_dut_o   <= 4'h0;
        end else if (hit_i && !first_valid_o) begin
            first_valid_o <= 1'b1;
            first_vec_o   <= vec_i;
            first_gold_o  <= gold_i;
            first_dut_o   <= dut_i;
        end else begin
            first_valid_o <= first_valid_o;
            first_vec_o   <= first_vec_o;
            first_gold_o  <= first_gold_o;
            first_dut_o   <= first_dut_o;
        end
    end

endmodule

// File: rtl/alu_sweep_checker.sv
// Exhaustive {op,A,B} sweep comparing a golden and a suspect 4-bit ALU.
// Define ALU_SWEEP_CAPTURE_EN to build the first-mismatch capture registers.
import alu_sweep_pkg::*;

module alu_sweep_checker #(
    parameter int CNT_W  = 11,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort_on_fail,
    output logic [3:0]       A,
    output logic [3:0]       B,
    output logic [1:0]       op,
    input  logic [3:0]       result_gold,
    input  logic [3:0]       result_dut,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic             first_valid,
    output logic [VEC_W-1:0] first_vec,
    output logic [3:0]       first_gold,
    output logic [3:0]       first_dut
);

    localparam int               WAIT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    state_e            state_q;
    logic [VEC_W-1:0]  vec_q;
    logic [WAIT_W-1:0] wait_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic              mismatch_s;
    logic              start_ok_s;
    logic              end_s;

    // Compare, saturating count and sweep-end decision for the current cycle.
    always_comb begin
        mismatch_s = (state_q == ST_CHECK) && (result_gold != result_dut);
        start_ok_s = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        end_s      = (vec_q == LAST_VEC) || (abort_on_fail && mismatch_s);
        if (mismatch_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Sweep FSM; the operand bus is the vector register itself, so it holds in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            wait_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_ok_s) begin
                        state_q <= ST_SETTLE;
                        vec_q   <= '0;
                        wait_q  <= WAIT_INIT;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (wait_q == '0) begin
                        state_q <= ST_CHECK;
                    end else begin
                        wait_q <= wait_q - WAIT_W'(1);
                    end
                end
                ST_CHECK: begin
                    cnt_q <= cnt_d;
                    if (end_s) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (cnt_d == '0);
                    end else begin
                        state_q <= ST_SETTLE;
                        vec_q   <= vec_q + 10'd1;
                        wait_q  <= WAIT_INIT;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign op           = vec_q[9:8];
    assign A            = vec_q[7:4];
    assign B            = vec_q[3:0];
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign mismatch_cnt = cnt_q;

`ifdef ALU_SWEEP_CAPTURE_EN
    alu_sweep_capture u_capture (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (start_ok_s),
        .hit_i        (mismatch_s),
        .vec_i        (vec_q),
        .gold_i       (result_gold),
        .dut_i        (result_dut),
        .first_valid_o(first_valid),
        .first_vec_o  (first_vec),
        .first_gold_o (first_gold),
        .first_dut_o  (first_dut)
    );
`else
    assign first_valid = 1'b0;
    assign first_vec   = '0;
    assign first_gold  = 4'h0;
    assign first_dut   = 4'h0;
`endif

endmodule

// File: tb/tb_alu_sweep_checker.sv
// Directed bench for alu_sweep_checker with a behavioural golden/suspect ALU pair.
import alu_sweep_pkg::*;

module tb_alu_sweep_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort_on_fail = 1'b0;
    int          mode = 0;
    int          checks = 0;
    int          errors = 0;

    logic [3:0]  a, b, a4, b4;
    logic [1:0]  op, op4;
    logic [3:0]  gold, dut_res, gold4, dut_res4;
    logic        busy, done, pass, fv;
    logic [10:0] cnt;
    logic [9:0]  fvec;
    logic [3:0]  fgold, fdut;
    logic        busy4, done4, pass4, fv4;
    logic [3:0]  cnt4;
    logic [9:0]  fvec4;
    logic [3:0]  fgold4, fdut4;

    always #5 clk = ~clk;

    function automatic logic [3:0] gold_f(input logic [1:0] o, input logic [3:0] x, input logic [3:0] y);
        case (o)
            OP_ADD:  return x + y;
            OP_SUB:  return x - y;
            OP_AND:  return x & y;
            default: return x | y;
        endcase
    endfunction

    // mode 1: zero at vec 0x0FF, mode 2: inverted everywhere, mode 3: bit0 flip at 0x2A5
    function automatic logic [3:0] dut_f(input logic [1:0] o, input logic [3:0] x, input logic [3:0] y, input int m);
        logic [3:0] g;
        g = gold_f(o, x, y);
        case (m)
            1:       return ({o, x, y} == 10'h0FF) ? 4'h0 : g;
            2:       return ~g;
            3:       return ({o, x, y} == 10'h2A5) ? (g ^ 4'h1) : g;
            default: return g;
        endcase
    endfunction

    always_comb begin
        gold     = gold_f(op, a, b);
        dut_res  = dut_f(op, a, b, mode);
        gold4    = gold_f(op4, a4, b4);
        dut_res4 = dut_f(op4, a4, b4, mode);
    end

    alu_sweep_checker #(.CNT_W(11), .SETTLE(1)) dut (
        .clk(clk), .rst(rst), .start(start), .abort_on_fail(abort_on_fail),
        .A(a), .B(b), .op(op), .result_gold(gold), .result_dut(dut_res),
        .busy(busy), .done(done), .pass(pass), .mismatch_cnt(cnt),
        .first_valid(fv), .first_vec(fvec), .first_gold(fgold), .first_dut(fdut)
    );

    alu_sweep_checker #(.CNT_W(4), .SETTLE(1)) dut4 (
        .clk(clk), .rst(rst), .start(start), .abort_on_fail(abort_on_fail),
        .A(a4), .B(b4), .op(op4), .result_gold(gold4), .result_dut(dut_res4),
        .busy(busy4), .done(done4), .pass(pass4), .mismatch_cnt(cnt4),
        .first_valid(fv4), .first_vec(fvec4), .first_gold(fgold4), .first_dut(fdut4)
    );

    task automatic run_sweep(input int ignore_at, output int cycles);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_start: busy=%b done=%b, want busy=1 done=0", busy, done);
        end
        cycles = 0;
        while (done !== 1'b1 && cycles < 5000) begin
            @(posedge clk);
            cycles++;
            #1;
            start = (ignore_at != 0) && (cycles == ignore_at);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        checks++;
        if ({a, b, op, busy, done, pass, cnt, fv, fvec, fgold, fdut} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: A=%h B=%h op=%h busy=%b done=%b pass=%b cnt=%0d, want all 0",
                     a, b, op, busy, done, pass, cnt);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_clean_sweep();
        int cyc;
        mode = 0;
        run_sweep(0, cyc);
        checks++;
        if (cyc !== 2048) begin
            errors++;
            $display("FAIL clean_cycles: got %0d, want 2048", cyc);
        end
        checks++;
        if (pass !== 1'b1 || cnt !== 11'd0 || fv !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clean_result: pass=%b cnt=%0d fv=%b busy=%b, want 1 0 0 0", pass, cnt, fv, busy);
        end
        checks++;
        if ({op, a, b} !== 10'h3FF) begin
            errors++;
            $display("FAIL clean_hold_vec: got %h, want 3ff", {op, a, b});
        end
    endtask

    task automatic test_single_fault();
        int cyc;
        logic [9:0] ev;
        logic [3:0] eg, ed;
        logic       efv;
`ifdef ALU_SWEEP_CAPTURE_EN
        efv = 1'b1; ev = 10'h0FF; eg = 4'hE; ed = 4'h0;
`else
        efv = 1'b0; ev = 10'h000; eg = 4'h0; ed = 4'h0;
`endif
        mode = 1;
        run_sweep(0, cyc);
        checks++;
        if (cnt !== 11'd1 || pass !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL single_count: cnt=%0d pass=%b done=%b, want 1 0 1", cnt, pass, done);
        end
        checks++;
        if (fv !== efv || fvec !== ev || fgold !== eg || fdut !== ed) begin
            errors++;
            $display("FAIL single_capture: fv=%b vec=%h gold=%h dut=%h, want %b %h %h %h",
                     fv, fvec, fgold, fdut, efv, ev, eg, ed);
        end
    endtask

    task automatic test_inverted();
        int cyc;
        logic [3:0] eg, ed;
`ifdef ALU_SWEEP_CAPTURE_EN
        eg = 4'h0; ed = 4'hF;
`else
        eg = 4'h0; ed = 4'h0;
`endif
        mode = 2;
        run_sweep(0, cyc);
        checks++;
        if (cnt !== 11'd1024) begin
            errors++;
            $display("FAIL inverted_cnt11: got %0d, want 1024", cnt);
        end
        checks++;
        if (cnt4 !== 4'hF || done4 !== 1'b1 || pass4 !== 1'b0) begin
            errors++;
            $display("FAIL inverted_cnt4_sat: cnt=%0d done=%b pass=%b, want 15 1 0", cnt4, done4, pass4);
        end
        checks++;
        if (fvec !== 10'h000 || fgold !== eg || fdut !== ed) begin
            errors++;
            $display("FAIL inverted_capture: vec=%h gold=%h dut=%h, want 000 %h %h", fvec, fgold, fdut, eg, ed);
        end
    endtask

    task automatic test_abort();
        int cyc;
        logic [9:0] ev;
`ifdef ALU_SWEEP_CAPTURE_EN
        ev = 10'h2A5;
`else
        ev = 10'h000;
`endif
        mode = 3;
        abort_on_fail = 1'b1;
        run_sweep(0, cyc);
        abort_on_fail = 1'b0;
        checks++;
        if (cyc !== 1356) begin
            errors++;
            $display("FAIL abort_cycles: got %0d, want 1356", cyc);
        end
        checks++;
        if (cnt !== 11'd1 || op !== 2'h2 || a !== 4'hA || b !== 4'h5 || fvec !== ev) begin
            errors++;
            $display("FAIL abort_hold: cnt=%0d op=%h A=%h B=%h fvec=%h, want 1 2 a 5 %h", cnt, op, a, b, fvec, ev);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (600) @(posedge clk);
        #1;
        checks++;
        if ({op, a, b} !== 10'd300 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_vec: got %h busy=%b, want 12c busy=1", {op, a, b}, busy);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({a, b, op, busy, done, pass, cnt, fv, fvec} !== '0) begin
            errors++;
            $display("FAIL mid_reset_async: A=%h B=%h op=%h busy=%b done=%b cnt=%0d, want all 0",
                     a, b, op, busy, done, cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        run_sweep(0, cyc);
        checks++;
        if (cyc !== 2048 || pass !== 1'b1) begin
            errors++;
            $display("FAIL mid_restart: cycles=%0d pass=%b, want 2048 1", cyc, pass);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        mode = 1;
        run_sweep(20, cyc);
        checks++;
        if (cyc !== 2048 || cnt !== 11'd1) begin
            errors++;
            $display("FAIL start_while_busy: cycles=%0d cnt=%0d, want 2048 1", cyc, cnt);
        end
        mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || cnt !== 11'd0 || fv !== 1'b0 || pass !== 1'b0 || {op, a, b} !== 10'h000) begin
            errors++;
            $display("FAIL restart_clear: busy=%b done=%b cnt=%0d fv=%b pass=%b vec=%h, want 1 0 0 0 0 000",
                     busy, done, cnt, fv, pass, {op, a, b});
        end
        cyc = 0;
        while (done !== 1'b1 && cyc < 5000) begin
            @(posedge clk);
            cyc++;
            #1;
        end
        checks++;
        if (cyc !== 2048 || pass !== 1'b1) begin
            errors++;
            $display("FAIL restart_sweep: cycles=%0d pass=%b, want 2048 1", cyc, pass);
        end
    endtask

    initial begin
        test_reset();
        test_clean_sweep();
        test_single_fault();
        test_inverted();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
